sram_input_loader: RTL and testbench

SRAM_INPUT_LOADER -- requirements
Module: sram_input_loader

---
 rtl/sram_input_loader_pkg.sv | 28 ++
 rtl/sram_input_loader_write_port.sv | 59 +++++
 rtl/sram_input_loader.sv | 130 +++++++++++++
 tb/tb_sram_input_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_input_loader_pkg.sv
// Shared definitions for the SRAM input loader.
// Holds the loader FSM state encoding, the stream-format constants and a helper
// that validates a matrix dimension word.
package sram_input_loader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StNrows,
        StNcols,
        StData,
        StTerm,
        StRun,
        StWaitHi,
        StWaitLo,
        StErr
    } loader_state_e;

    localparam logic [15:0] TERMINATOR = 16'h00FF;
    localparam logic [15:0] MIN_DIM    = 16'd3;
    localparam logic [15:0] MAX_DIM    = 16'd16;
    localparam logic [11:0] ADDR_MAX   = 12'hFFF;

    // A dimension word is legal only when it lies in MIN_DIM..MAX_DIM.
    function automatic logic dim_ok(input logic [15:0] dim);
        return (dim >= MIN_DIM) && (dim <= MAX_DIM);
    endfunction

endpackage

// File: rtl/sram_input_loader_write_port.sv
// loader_write_port: registered write stage for the input SRAM.
// A request on wr_req_i is presented on the SRAM port one cycle later, using the
// current counter value as the address; the counter then advances (saturating
// at ADDR_MAX, never wrapping).
// Ports:
//   clk, reset_b  - clock, asynchronous active-low reset
//   wr_req_i      - write request this cycle
//   wr_data_i     - word to write
//   cnt_clr_i     - return the counter to 0x000
//   cnt_o         - address the next request will use
//   wr_addr_o     - SRAM write address
//   wr_data_o     - SRAM write data
//   wr_en_o       - one-cycle SRAM write strobe
module loader_write_port
    import sram_input_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wr_req_i,
    input  logic [15:0] wr_data_i,
    input  logic        cnt_clr_i,
    output logic [11:0] cnt_o,
    output logic [11:0] wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        wr_en_o
);

    logic [11:0] cnt_q;
    logic [11:0] addr_q;
    logic [15:0] data_q;
    logic        en_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q  <= 12'h000;
            addr_q <= 12'h000;
            data_q <= 16'h0000;
            en_q   <= 1'b0;
        end else begin
            en_q <= wr_req_i;
            if (wr_req_i) begin
                // Write uses the pre-increment address.
                addr_q <= cnt_q;
                data_q <= wr_data_i;
                if (cnt_q != ADDR_MAX) begin
                    cnt_q <= cnt_q + 12'd1;
                end
            end else if (cnt_clr_i) begin
                cnt_q <= 12'h000;
            end
        end
    end

    assign cnt_o     = cnt_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign wr_en_o   = en_q;

endmodule

// File: rtl/sram_input_loader.sv
// sram_input_loader: accepts a batch of matrices (nrows, ncols, row words...),
// writes every accepted word to the input SRAM, appends a terminator, starts the
// convolution datapath and reports completion.
// Ports:
//   clk, reset_b                     - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last - upstream word stream
//   loader_sram_write_*              - input-SRAM write port
//   dut_run                          - one-cycle datapath start pulse
//   dut_busy                         - datapath busy level
//   load_done                        - one-cycle pulse when the datapath finishes
//   load_err                         - sticky format/overflow error (cleared by reset)
module sram_input_loader (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic [11:0] loader_sram_write_address,
    output logic [15:0] loader_sram_write_data,
    output logic        loader_sram_write_enable,
    output logic        dut_run,
    input  logic        dut_busy,
    output logic        load_done,
    output logic        load_err
);

    import sram_input_loader_pkg::*;

    loader_state_e state_q;
    logic [4:0]    rows_left_q;
    logic          dut_run_q;
    logic          load_done_q;

    logic          xfer;
    logic          wr_req;
    logic [15:0]   wr_data;
    logic          cnt_clr;
    logic [11:0]   cnt;
    logic          overflow;

    assign in_ready = (state_q == StNrows) || (state_q == StNcols) || (state_q == StData);
    assign xfer     = in_valid && in_ready;
    // Accepting a word at 0xFFE or above would leave no room for the terminator.
    assign overflow = (cnt >= (ADDR_MAX - 12'd1));

    always_comb begin
        wr_req  = xfer || (state_q == StTerm);
        wr_data = (state_q == StTerm) ? TERMINATOR : in_data;
        cnt_clr = (state_q == StWaitLo) && !dut_busy;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= StIdle;
            rows_left_q <= 5'd0;
            dut_run_q   <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            dut_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) state_q <= StNrows;
                end
                StNrows: begin
                    if (xfer) begin
                        rows_left_q <= in_data[4:0];
                        if (overflow || in_last || !dim_ok(in_data)) state_q <= StErr;
                        else                                          state_q <= StNcols;
                    end
                end
                StNcols: begin
                    // ncols is only validated; each row arrives as a single word.
                    if (xfer) begin
                        if (overflow || in_last || !dim_ok(in_data)) state_q <= StErr;
                        else                                          state_q <= StData;
                    end
                end
                StData: begin
                    if (xfer) begin
                        rows_left_q <= rows_left_q - 5'd1;
                        if (overflow)                 state_q <= StErr;
                        else if (rows_left_q == 5'd1) state_q <= in_last ? StTerm : StNrows;
                        else if (in_last)             state_q <= StErr;
                    end
                end
                StTerm: begin
                    state_q   <= StRun;
                    dut_run_q <= 1'b1;
                end
                StRun: begin
                    state_q <= StWaitHi;
                end
                StWaitHi: begin
                    if (dut_busy) state_q <= StWaitLo;
                end
                StWaitLo: begin
                    if (!dut_busy) begin
                        state_q     <= StIdle;
                        load_done_q <= 1'b1;
                    end
                end
                StErr: begin
                    state_q <= StErr;
                end
                default: begin
                    state_q <= StErr;
                end
            endcase
        end
    end

    assign dut_run   = dut_run_q;
    assign load_done = load_done_q;
    assign load_err  = (state_q == StErr);

    loader_write_port u_write_port (
        .clk       (clk),
        .reset_b   (reset_b),
        .wr_req_i  (wr_req),
        .wr_data_i (wr_data),
        .cnt_clr_i (cnt_clr),
        .cnt_o     (cnt),
        .wr_addr_o (loader_sram_write_address),
        .wr_data_o (loader_sram_write_data),
        .wr_en_o   (loader_sram_write_enable)
    );

endmodule

// File: tb/tb_sram_input_loader.sv
module tb_sram_input_loader;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        dut_run;
    logic        dut_busy = 1'b0;
    logic        load_done;
    logic        load_err;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] wa[$];
    logic [15:0] wd[$];
    int          run_cnt = 0;

    sram_input_loader dut (
        .clk                       (clk),
        .reset_b                   (reset_b),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_data                   (in_data),
        .in_last                   (in_last),
        .loader_sram_write_address (wr_addr),
        .loader_sram_write_data    (wr_data),
        .loader_sram_write_enable  (wr_en),
        .dut_run                   (dut_run),
        .dut_busy                  (dut_busy),
        .load_done                 (load_done),
        .load_err                  (load_err)
    );

    always #5 clk = ~clk;

    // Write/pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_b) begin
            if (wr_en) begin
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
            end
            if (dut_run) run_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until it is accepted (called on a falling edge).
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        dut_busy = 1'b0;
        reset_b  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        wa.delete();
        wd.delete();
        run_cnt = 0;
        reset_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input logic [11:0] a0, input logic [15:0] e[$]);
        int n;
        chk({tag, "_nwrites"}, wa.size(), e.size());
        n = (wa.size() < e.size()) ? wa.size() : e.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, {20'd0, wa[i]}, {20'd0, a0 + 12'(i)});
            chk({tag, "_data"}, {16'd0, wd[i]}, {16'd0, e[i]});
        end
    endtask

    // Datapath model: busy rises 3 cycles after dut_run, falls 20 cycles later.
    task automatic finish_batch(input string tag);
        int n;
        n = 0;
        while (!dut_run && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_run_seen"}, {31'd0, dut_run}, 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_run_single"}, run_cnt, 1);
        dut_busy = 1'b1;
        repeat (20) @(negedge clk);
        chk({tag, "_done_early"}, {31'd0, load_done}, 32'd0);
        dut_busy = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, load_done}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_single"}, {31'd0, load_done}, 32'd0);
    endtask

    task automatic send_fill(input logic last_word);
        // 227 16x16 matrices + one 6-row matrix = 4094 words (0x000..0xFFD).
        for (int m = 0; m < 227; m++) begin
            send(16'd16, 1'b0);
            send(16'd16, 1'b0);
            for (int r = 0; r < 16; r++) send(16'(m * 16 + r), 1'b0);
        end
        send(16'd6, 1'b0);
        send(16'd3, 1'b0);
        for (int r = 0; r < 5; r++) send(16'hAA00 + 16'(r), 1'b0);
        send(16'hAA05, last_word);
    endtask

    initial begin
        logic [15:0] e[$];

        // Reset state
        reset_b = 1'b0;
        #3;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, wr_en}, 32'd0);
        chk("rst_addr", {20'd0, wr_addr}, 32'd0);
        chk("rst_run", {31'd0, dut_run}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        do_reset();

        // Single 4x4 matrix
        send(16'h0004, 1'b0);
        send(16'h0004, 1'b0);
        send(16'h000F, 1'b0);
        send(16'h00F0, 1'b0);
        send(16'h0F00, 1'b0);
        send(16'hF000, 1'b1);
        finish_batch("m4");
        e = '{16'h0004, 16'h0004, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h00FF};
        chk_writes("m4", 12'h000, e);
        chk("m4_err", {31'd0, load_err}, 32'd0);

        // 3x3 then 5x5 without reset: counter must restart at 0x000
        wa.delete();
        wd.delete();
        run_cnt = 0;
        send(16'd3, 1'b0);
        send(16'd3, 1'b0);
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        send(16'h0303, 1'b0);
        send(16'd5, 1'b0);
        send(16'd5, 1'b0);
        send(16'h0A01, 1'b0);
        send(16'h0A02, 1'b0);
        send(16'h0A03, 1'b0);
        send(16'h0A04, 1'b0);
        send(16'h0A05, 1'b1);
        finish_batch("m35");
        e = '{16'd3, 16'd3, 16'h0101, 16'h0202, 16'h0303, 16'd5, 16'd5,
              16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h00FF};
        chk_writes("m35", 12'h000, e);

        // ncols out of range
        do_reset();
        send(16'h0004, 1'b0);
        send(16'h0011, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (4) @(negedge clk);
        chk("ncols_err", {31'd0, load_err}, 32'd1);
        chk("ncols_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        e = '{16'h0004, 16'h0011};
        chk_writes("ncols", 12'h000, e);
        chk("ncols_run", run_cnt, 0);

        // nrows below minimum
        do_reset();
        send(16'h0002, 1'b0);
        @(negedge clk);
        chk("nrows2_err", {31'd0, load_err}, 32'd1);

        // Early in_last
        do_reset();
        send(16'h0004, 1'b0);
        send(16'h0004, 1'b0);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        repeat (6) @(negedge clk);
        chk("early_err", {31'd0, load_err}, 32'd1);
        e = '{16'h0004, 16'h0004, 16'h1111, 16'h2222};
        chk_writes("early", 12'h000, e);
        chk("early_run", run_cnt, 0);

        // Asynchronous reset mid-DATA with in_valid held
        do_reset();
        send(16'h0004, 1'b0);
        send(16'h0004, 1'b0);
        send(16'h1111, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h2222;
        @(posedge clk);
        #2;
        chk("pre_rst_we", {31'd0, wr_en}, 32'd1);
        reset_b = 1'b0;
        #1;
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_we", {31'd0, wr_en}, 32'd0);
        chk("arst_addr", {20'd0, wr_addr}, 32'd0);
        chk("arst_data", {16'd0, wr_data}, 32'd0);
        chk("arst_misc", {29'd0, dut_run, load_done, load_err}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        wa.delete();
        wd.delete();
        run_cnt = 0;
        reset_b = 1'b1;
        @(negedge clk);
        send(16'd3, 1'b0);
        send(16'd3, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        finish_batch("fresh");
        e = '{16'd3, 16'd3, 16'h0001, 16'h0002, 16'h0003, 16'h00FF};
        chk_writes("fresh", 12'h000, e);

        // Boundary: terminator lands exactly at 0xFFE
        do_reset();
        send_fill(1'b1);
        finish_batch("full");
        chk("full_nwrites", wa.size(), 4095);
        chk("full_term_addr", {20'd0, wa[wa.size() - 1]}, 32'h0FFE);
        chk("full_term_data", {16'd0, wd[wd.size() - 1]}, 32'h00FF);
        chk("full_err", {31'd0, load_err}, 32'd0);

        // Overflow: a word accepted at 0xFFE goes to ERR (word still written)
        wa.delete();
        wd.delete();
        run_cnt = 0;
        send_fill(1'b0);
        send(16'd3, 1'b0);
        repeat (4) @(negedge clk);
        chk("ovf_err", {31'd0, load_err}, 32'd1);
        chk("ovf_nwrites", wa.size(), 4095);
        chk("ovf_addr", {20'd0, wa[wa.size() - 1]}, 32'h0FFE);
        chk("ovf_data", {16'd0, wd[wd.size() - 1]}, 32'h0003);
        chk("ovf_run", run_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
